// File: rtl/fp16_dot_accum_if.sv
// rtl/fp16_dot_accum_if.sv - product-beat input and dot-product result bundle for fp16_dot_accum
// Purpose: groups the product beat (in_valid, in_last, qa..qd) driven by the
//   FP8 vector multiplier and the dot-product result (out_valid, acc_out,
//   out_count, out_ovf, out_nan) returned by the accumulator.
// Ports (modports):
//   master - drives the product beat, observes the result (multiplier side / bench)
//   slave  - consumes the product beat, drives the result (fp16_dot_accum)
interface fp16_dot_accum_if #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_last;
  logic [15:0]      qa;
  logic [15:0]      qb;
  logic [15:0]      qc;
  logic [15:0]      qd;
  logic             out_valid;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_nan;

  modport master (
    output in_valid, in_last, qa, qb, qc, qd,
    input  out_valid, acc_out, out_count, out_ovf, out_nan
  );

  modport slave (
    input  in_valid, in_last, qa, qb, qc, qd,
    output out_valid, acc_out, out_count, out_ovf, out_nan
  );
endinterface

// File: rtl/fp16_dot_accum.sv
// rtl/fp16_dot_accum.sv - FP16 product-to-fixed-point dot-product accumulator
// Purpose: converts four FP16 products per beat to signed fixed point
//   (24 fractional bits), sums them and accumulates across beats until a beat
//   tagged in_last, then emits one result with beat count and sticky flags.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - fp16_dot_accum_if.slave: product beat in, dot-product result out
// Configuration macro: FP16_ACC_SATURATE_EN
//   defined   - accumulator clamps to the signed ACC_W range on overflow
//   undefined - accumulator wraps modulo 2^ACC_W
module fp16_dot_accum #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  fp16_dot_accum_if.slave bus
);

  localparam int TERM_W = 42;
  localparam int SUM_W  = 44;

  // Largest FP16 normal is (2^11-1) << 29, so a 42-bit signed term always fits.
  function automatic logic [TERM_W-1:0] fp16_to_fix(input logic [15:0] h);
    logic [4:0]        e;
    logic [TERM_W-1:0] mag;
    e   = h[14:10];
    mag = {{(TERM_W-11){1'b0}}, (e != 5'd0), h[9:0]};
    if (e == 5'd31) begin
      mag = '0;
    end else if (e != 5'd0) begin
      mag = mag << (e - 5'd1);
    end
    return h[15] ? (~mag + {{(TERM_W-1){1'b0}}, 1'b1}) : mag;
  endfunction

  function automatic logic is_special(input logic [15:0] h);
    return h[14:10] == 5'd31;
  endfunction

  // Stage S1: converted terms
  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q,  s1_last_d;
  logic              s1_nan_q,   s1_nan_d;
  logic [TERM_W-1:0] s1_term_q [4];
  logic [TERM_W-1:0] s1_term_d [4];

  // Stage S2: running accumulation
  logic              first_q, first_d;
  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              ovf_q,   ovf_d;
  logic              nan_q,   nan_d;
  logic              done_q,  done_d;

  // Output registers
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_acc_q,   out_acc_d;
  logic [CNT_W-1:0]  out_cnt_q,   out_cnt_d;
  logic              out_ovf_q,   out_ovf_d;
  logic              out_nan_q,   out_nan_d;

  logic [SUM_W-1:0]  beat_sum;
  logic [ACC_W:0]    acc_base;
  logic [ACC_W:0]    sum_wide;
  logic              ovf_now;

  always_comb begin
    s1_valid_d   = bus.in_valid;
    s1_last_d    = bus.in_valid & bus.in_last;
    s1_nan_d     = bus.in_valid & (is_special(bus.qa) | is_special(bus.qb) |
                                   is_special(bus.qc) | is_special(bus.qd));
    s1_term_d[0] = fp16_to_fix(bus.qa);
    s1_term_d[1] = fp16_to_fix(bus.qb);
    s1_term_d[2] = fp16_to_fix(bus.qc);
    s1_term_d[3] = fp16_to_fix(bus.qd);
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < 4; i++) begin
      beat_sum = beat_sum + {{(SUM_W-TERM_W){s1_term_q[i][TERM_W-1]}}, s1_term_q[i]};
    end
    // A first beat starts from zero rather than the stale accumulator.
    acc_base = first_q ? '0 : {acc_q[ACC_W-1], acc_q};
    sum_wide = {{(ACC_W+1-SUM_W){beat_sum[SUM_W-1]}}, beat_sum} + acc_base;
    // One guard bit: true sum is out of range when it disagrees with the ACC_W sign.
    ovf_now  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

    first_d = first_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    nan_d   = nan_q;
    done_d  = 1'b0;
    if (s1_valid_q) begin
      if (ovf_now) begin
`ifdef FP16_ACC_SATURATE_EN
        acc_d = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
        acc_d = sum_wide[ACC_W-1:0];
`endif
      end else begin
        acc_d = sum_wide[ACC_W-1:0];
      end
      if (first_q) begin
        cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      ovf_d   = (ovf_q & ~first_q) | ovf_now;
      nan_d   = (nan_q & ~first_q) | s1_nan_q;
      first_d = s1_last_q;
      done_d  = s1_last_q;
    end
  end

  // The result is taken from S2 one cycle after its last beat, so a new beat
  // landing in S2 on that same edge overwrites acc only after it is captured.
  always_comb begin
    out_valid_d = done_q;
    out_acc_d   = out_acc_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;
    out_nan_d   = out_nan_q;
    if (done_q) begin
      out_acc_d = acc_q;
      out_cnt_d = cnt_q;
      out_ovf_d = ovf_q;
      out_nan_d = nan_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_nan_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        s1_term_q[i] <= '0;
      end
      first_q     <= 1'b1;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      nan_q       <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_nan_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_nan_q    <= s1_nan_d;
      for (int i = 0; i < 4; i++) begin
        s1_term_q[i] <= s1_term_d[i];
      end
      first_q     <= first_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      nan_q       <= nan_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
      out_nan_q   <= out_nan_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = out_acc_q;
  assign bus.out_count = out_cnt_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_nan   = out_nan_q;

endmodule

// File: tb/tb_fp16_dot_accum.sv
// tb/tb_fp16_dot_accum.sv - self-checking bench for fp16_dot_accum at ACC_W=48 and ACC_W=44
module tb_fp16_dot_accum;

  typedef struct {
    bit     valid;
    longint acc [2];
    bit     ovf [2];
    longint cnt;
    bit     nan;
  } exp_t;

  typedef struct {
    longint acc;
    longint cnt;
    bit     ovf;
    bit     nan;
  } res_t;

  logic clk;
  logic rst;

  fp16_dot_accum_if #(.ACC_W(48), .CNT_W(16)) bus48 ();
  fp16_dot_accum_if #(.ACC_W(44), .CNT_W(16)) bus44 ();

  fp16_dot_accum #(.ACC_W(48), .CNT_W(16)) dut48 (.clk(clk), .rst(rst), .bus(bus48));
  fp16_dot_accum #(.ACC_W(44), .CNT_W(16)) dut44 (.clk(clk), .rst(rst), .bus(bus44));

  int n_chk;
  int n_fail;

  res_t cap48 [$];
  res_t cap44 [$];
  res_t mdl44 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Value of an FP16 number in units of 2^-24, from its real value.
  function automatic longint fp16_units(input logic [15:0] h);
    int  e;
    int  m;
    real v;
    real scale;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 31) return 0;
    scale = 1.0;
    if (e == 0) begin
      for (int i = 0; i < 14; i++) scale = scale / 2.0;
      v = (m / 1024.0) * scale;
    end else if (e >= 15) begin
      for (int i = 0; i < e - 15; i++) scale = scale * 2.0;
      v = (1.0 + m / 1024.0) * scale;
    end else begin
      for (int i = 0; i < 15 - e; i++) scale = scale / 2.0;
      v = (1.0 + m / 1024.0) * scale;
    end
    for (int i = 0; i < 24; i++) v = v * 2.0;
    return h[15] ? -longint'(v) : longint'(v);
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] d, input logic v, input logic l);
    @(negedge clk);
    bus48.qa = a; bus48.qb = b; bus48.qc = c; bus48.qd = d;
    bus44.qa = a; bus44.qb = b; bus44.qc = c; bus44.qd = d;
    bus48.in_valid = v; bus48.in_last = l;
    bus44.in_valid = v; bus44.in_last = l;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
  endtask

  // Reference model and per-cycle compare.
  initial begin : model_and_check
    exp_t   d0, d1, h, z;
    bit     m_first;
    longint m_acc [2];
    bit     m_ovf [2];
    longint m_cnt;
    bit     m_nan;
    bit     ev;
    longint bs, s, lo, hi;
    bit     o, bnan;
    int     w;
    logic [15:0] qv [4];

    z.valid = 0; z.acc[0] = 0; z.acc[1] = 0; z.ovf[0] = 0; z.ovf[1] = 0; z.cnt = 0; z.nan = 0;
    d0 = z; d1 = z; h = z;
    m_first = 1; m_acc[0] = 0; m_acc[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0; m_cnt = 0; m_nan = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        d0 = z; d1 = z; h = z; ev = 0;
        m_first = 1; m_acc[0] = 0; m_acc[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0; m_cnt = 0; m_nan = 0;
      end else begin
        ev = d1.valid;
        if (d1.valid) h = d1;
        d1 = d0;
        d0 = z;
        if (bus48.in_valid) begin
          qv[0] = bus48.qa; qv[1] = bus48.qb; qv[2] = bus48.qc; qv[3] = bus48.qd;
          bs = 0; bnan = 0;
          for (int i = 0; i < 4; i++) begin
            bs = bs + fp16_units(qv[i]);
            if (qv[i][14:10] == 5'd31) bnan = 1;
          end
          for (int k = 0; k < 2; k++) begin
            w  = (k == 0) ? 48 : 44;
            hi = (longint'(1) <<< (w - 1)) - 1;
            lo = -(longint'(1) <<< (w - 1));
            s  = (m_first ? 0 : m_acc[k]) + bs;
            o  = (s > hi) || (s < lo);
            if (o) begin
`ifdef FP16_ACC_SATURATE_EN
              s = (s > hi) ? hi : lo;
`else
              s = (s <<< (64 - w)) >>> (64 - w);
`endif
            end
            m_acc[k] = s;
            m_ovf[k] = (m_first ? 1'b0 : m_ovf[k]) | o;
          end
          m_cnt   = m_first ? 1 : ((m_cnt + 1 > 65535) ? 65535 : m_cnt + 1);
          m_nan   = (m_first ? 1'b0 : m_nan) | bnan;
          m_first = 0;
          if (bus48.in_last) begin
            d0.valid = 1; d0.acc = m_acc; d0.ovf = m_ovf; d0.cnt = m_cnt; d0.nan = m_nan;
            m_first = 1;
          end
        end
      end
      #1;
      chk("valid48", longint'(bus48.out_valid), longint'(ev));
      chk("valid44", longint'(bus44.out_valid), longint'(ev));
      chk("acc48",   longint'($signed(bus48.acc_out)), h.acc[0]);
      chk("acc44",   longint'($signed(bus44.acc_out)), h.acc[1]);
      chk("cnt48",   longint'(bus48.out_count), h.cnt);
      chk("cnt44",   longint'(bus44.out_count), h.cnt);
      chk("ovf48",   longint'(bus48.out_ovf), longint'(h.ovf[0]));
      chk("ovf44",   longint'(bus44.out_ovf), longint'(h.ovf[1]));
      chk("nan48",   longint'(bus48.out_nan), longint'(h.nan));
      chk("nan44",   longint'(bus44.out_nan), longint'(h.nan));
      if (bus48.out_valid) begin
        cap48.push_back('{acc: longint'(bus48.acc_out), cnt: longint'(bus48.out_count),
                          ovf: bus48.out_ovf, nan: bus48.out_nan});
      end
      if (bus44.out_valid) begin
        cap44.push_back('{acc: longint'(bus44.acc_out), cnt: longint'(bus44.out_count),
                          ovf: bus44.out_ovf, nan: bus44.out_nan});
      end
      if (ev) begin
        mdl44.push_back('{acc: h.acc[1] & ((longint'(1) <<< 44) - 1), cnt: h.cnt,
                          ovf: h.ovf[1], nan: h.nan});
      end
    end
  end

  initial begin : stim
    longint wrap44;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus48.in_valid = 1'b1; bus48.in_last = 1'b1;
    bus44.in_valid = 1'b1; bus44.in_last = 1'b1;
    bus48.qa = 16'h3C00; bus48.qb = 16'h0; bus48.qc = 16'h0; bus48.qd = 16'h0;
    bus44.qa = 16'h3C00; bus44.qb = 16'h0; bus44.qc = 16'h0; bus44.qd = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus48.in_valid = 1'b0; bus44.in_valid = 1'b0;

    // Single beat: 6 - 3 + 2 - 4 = 1.0
    drive(16'h4600, 16'hC200, 16'h4000, 16'hC400, 1'b1, 1'b1);
    idle(4);

    // Two beats back-to-back, then an immediate single-beat product
    drive(16'h4600, 16'hC200, 16'h4000, 16'hC400, 1'b1, 1'b0);
    drive(16'h4080, 16'hC480, 16'h4200, 16'hC600, 1'b1, 1'b1);
    drive(16'h3C00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
    idle(4);

    // Subnormal, negative zero, max normal, infinity
    drive(16'h0001, 16'h8000, 16'h7BFF, 16'h7C00, 1'b1, 1'b1);
    idle(4);

    // Overflow at 44 bits on the third beat, then a clean product
    drive(16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF, 1'b1, 1'b0);
    drive(16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF, 1'b1, 1'b0);
    drive(16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF, 1'b1, 1'b1);
    drive(16'h3C00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
    idle(4);

    // Reset mid-product with a beat presented during reset
    drive(16'h4600, 16'hC200, 16'h4000, 16'hC400, 1'b1, 1'b0);
    drive(16'h4600, 16'hC200, 16'h4000, 16'hC400, 1'b1, 1'b0);
    drive(16'h3C00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
    rst = 1'b1;
    drive(16'h4000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
    rst = 1'b0;
    idle(6);

    chk("results48", longint'(cap48.size()), 7);
    chk("results44", longint'(cap44.size()), 7);
    if (cap48.size() == 7 && cap44.size() == 7 && mdl44.size() == 7) begin
`ifdef FP16_ACC_SATURATE_EN
      wrap44 = 64'h7FF_FFFF_FFFF;
`else
      wrap44 = 64'hBFE_8000_0000;
`endif
      chk("single_acc",   cap48[0].acc, 64'h0000_0100_0000);
      chk("single_cnt",   cap48[0].cnt, 1);
      chk("two_acc",      cap48[1].acc, 64'hFFFF_FBC0_0000);
      chk("two_cnt",      cap48[1].cnt, 2);
      chk("follow_acc",   cap48[2].acc, 64'h0000_0100_0000);
      chk("follow_cnt",   cap48[2].cnt, 1);
      chk("edge_acc",     cap48[3].acc, 64'h00FF_E000_0001);
      chk("edge_nan",     longint'(cap48[3].nan), 1);
      chk("big48_acc",    cap48[4].acc, 64'h0BFE_8000_0000);
      chk("big48_ovf",    longint'(cap48[4].ovf), 0);
      chk("ovf44_acc",    cap44[4].acc, wrap44);
      chk("ovf44_ovf",    longint'(cap44[4].ovf), 1);
      chk("ovf44_cnt",    cap44[4].cnt, 3);
      chk("clean44_ovf",  longint'(cap44[5].ovf), 0);
      chk("rst_acc",      cap48[6].acc, 64'h0000_0200_0000);
      chk("rst_cnt",      cap48[6].cnt, 1);
      chk("model_two44",  mdl44[1].acc, 64'hFFF_FBC0_0000);
      chk("model_ovf44",  mdl44[4].acc, wrap44);
      chk("model_edge",   mdl44[3].acc, 64'h0FF_E000_0001);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
